dai_rxbuf_bank: RTL and testbench

//  Per-input receive buffering between NUM_CH spdif_dai_varclk instances and the mixer.

---
 rtl/dai_rxbuf_bank_pkg.sv | 28 ++
 rtl/dai_rxbuf_bank_stream.sv | 109 ++++++++++
 rtl/dai_rxbuf_bank.sv | 108 ++++++++++
 tb/tb_dai_rxbuf_bank.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dai_rxbuf_bank_pkg.sv
// Shared types and helpers for the DAI receive buffer bank.
package dai_rxbuf_bank_pkg;

  localparam int unsigned SAMPLE_W = 24;

  // Per-stream buffer event reported on the cycle it happens
  typedef enum logic [1:0] {
    XRUN_NONE  = 2'd0,
    XRUN_OVER  = 2'd1,
    XRUN_UNDER = 2'd2
  } xrun_e;

  // Combinational pop response of one stream
  typedef struct packed {
    xrun_e                 xrun;
    logic [SAMPLE_W-1:0]   data;
  } pop_resp_t;

  // Stream s belongs to channel s/2; even streams carry L, odd streams carry R
  function automatic int unsigned stream_ch(input int unsigned s);
    return s / 2;
  endfunction

  function automatic logic stream_is_left(input int unsigned s);
    return (s % 2) == 0;
  endfunction

endpackage

// File: rtl/dai_rxbuf_bank_stream.sv
// One L or R ring buffer: storage, pointers, fill, prefill latch, held sample.
module dai_rxbuf_bank_stream
  import dai_rxbuf_bank_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned PREFILL    = 4,
  parameter int unsigned UNDER_HOLD = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_flush,
  input  logic                i_wr,
  input  logic [SAMPLE_W-1:0] i_wdata,
  input  logic                i_pop,
  output pop_resp_t           o_resp_c,
  output logic                o_primed
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W  = DEPTH_LOG2;
  localparam int unsigned FILL_W = DEPTH_LOG2 + 1;
  localparam logic        HOLD   = (UNDER_HOLD != 0);

  logic [SAMPLE_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [FILL_W-1:0]   r_fill;
  logic                r_primed;
  logic [SAMPLE_W-1:0] r_held;

  logic                w_empty;
  logic                w_full;
  logic                w_take;
  logic                w_under;
  logic                w_over;
  logic [FILL_W-1:0]   w_fill_nxt;

  // Pops act on the pre-write state; a draining pop frees the slot a full-buffer write needs
  assign w_empty = (r_fill == '0);
  assign w_full  = (r_fill == FILL_W'(DEPTH));
  assign w_take  = i_pop & r_primed & ~w_empty & ~i_flush;
  assign w_under = i_pop & r_primed & w_empty & ~i_flush;
  assign w_over  = i_wr & w_full & ~w_take & ~i_flush;

  // Pop response data and event classification
  always_comb begin
    o_resp_c = '{xrun: XRUN_NONE, data: '0};
    if (w_take) begin
      o_resp_c.data = r_mem[r_rd_ptr];
    end else if (w_under) begin
      o_resp_c.data = HOLD ? r_held : '0;
      o_resp_c.xrun = XRUN_UNDER;
    end
    if (w_over) begin
      o_resp_c.xrun = XRUN_OVER;
    end
  end

  // Next fill level; an overrunning write leaves it pinned at DEPTH
  always_comb begin
    w_fill_nxt = r_fill;
    if (i_wr && !w_over && !w_take) begin
      w_fill_nxt = r_fill + FILL_W'(1);
    end else if (w_take && !i_wr) begin
      w_fill_nxt = r_fill - FILL_W'(1);
    end
  end

  // Sample storage, no reset needed since fill gates every read
  always_ff @(posedge clk) begin
    if (i_wr && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer, fill, prefill latch and held-sample state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_primed <= 1'b0;
      r_held   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_primed <= 1'b0;
      r_held   <= '0;
    end else begin
      if (i_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_take || w_over) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_fill <= w_fill_nxt;
      if (w_fill_nxt >= FILL_W'(PREFILL)) begin
        r_primed <= 1'b1;
      end
      if (w_take) begin
        r_held <= r_mem[r_rd_ptr];
      end
    end
  end

  assign o_primed = r_primed;

endmodule

// File: rtl/dai_rxbuf_bank.sv
// Receive buffer bank: per-channel L/R ring buffers, pop arbitration and output mux.
module dai_rxbuf_bank
  import dai_rxbuf_bank_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned PREFILL    = 4,
  parameter int unsigned UNDER_HOLD = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          flush_i,
  input  logic [NUM_CH-1:0]          wr_i,
  input  logic [NUM_CH-1:0]          lrck_i,
  input  logic [SAMPLE_W*NUM_CH-1:0] wdata_i,
  input  logic [2*NUM_CH-1:0]        pop_i,
  output logic [2*NUM_CH-1:0]        ack_o,
  output logic [SAMPLE_W-1:0]        data_o,
  output logic [NUM_CH-1:0]          primed_o,
  output logic [2*NUM_CH-1:0]        xrun_o,
  input  logic                       xrun_clr_i
);

  localparam int unsigned NUM_ST = 2 * NUM_CH;

  logic [NUM_ST-1:0]   w_grant;
  logic [NUM_ST-1:0]   w_wr;
  logic [NUM_ST-1:0]   w_flush;
  logic [NUM_ST-1:0]   w_primed;
  logic [NUM_ST-1:0]   w_xevt;
  pop_resp_t           w_resp [NUM_ST];
  logic [SAMPLE_W-1:0] w_data;

  logic [NUM_ST-1:0]   r_ack;
  logic [SAMPLE_W-1:0] r_data;
  logic [NUM_CH-1:0]   r_primed;
  logic [NUM_ST-1:0]   r_xrun;

  // Fixed priority: lowest-index pop wins, the rest are dropped
  always_comb begin
    logic w_found;
    w_grant = '0;
    w_found = 1'b0;
    for (int s = 0; s < int'(NUM_ST); s++) begin
      if (pop_i[s] && !w_found) begin
        w_grant[s] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  for (genvar gs = 0; gs < int'(NUM_ST); gs++) begin : g_stream
    localparam int unsigned CH   = stream_ch(gs);
    localparam logic        IS_L = stream_is_left(gs);

    assign w_wr[gs]    = wr_i[CH] & (lrck_i[CH] == IS_L);
    assign w_flush[gs] = flush_i[CH];
    assign w_xevt[gs]  = (w_resp[gs].xrun != XRUN_NONE);

    dai_rxbuf_bank_stream #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .PREFILL    (PREFILL),
      .UNDER_HOLD (UNDER_HOLD)
    ) u_stream (
      .clk      (clk),
      .rst      (rst),
      .i_flush  (w_flush[gs]),
      .i_wr     (w_wr[gs]),
      .i_wdata  (wdata_i[SAMPLE_W*CH +: SAMPLE_W]),
      .i_pop    (w_grant[gs]),
      .o_resp_c (w_resp[gs]),
      .o_primed (w_primed[gs])
    );
  end

  // Select the granted stream's response; zero when nothing is served
  always_comb begin
    w_data = '0;
    for (int s = 0; s < int'(NUM_ST); s++) begin
      if (w_grant[s]) begin
        w_data = w_resp[s].data;
      end
    end
  end

  // Registered ack/data, sticky xrun flags (new events beat clear) and primed status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack    <= '0;
      r_data   <= '0;
      r_primed <= '0;
      r_xrun   <= '0;
    end else begin
      r_ack  <= w_grant;
      r_data <= w_data;
      r_xrun <= (xrun_clr_i ? '0 : r_xrun) | w_xevt;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        r_primed[c] <= w_primed[2*c] & w_primed[2*c+1];
      end
    end
  end

  assign ack_o    = r_ack;
  assign data_o   = r_data;
  assign primed_o = r_primed;
  assign xrun_o   = r_xrun;

endmodule

// File: tb/tb_dai_rxbuf_bank.sv
// Self-checking bench for dai_rxbuf_bank with a queue-based reference model and scoreboard.
module tb_dai_rxbuf_bank;

  localparam int unsigned NCH     = 2;
  localparam int unsigned NST     = 4;
  localparam int unsigned DLOG2   = 4;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned PREFILL = 4;
  localparam int unsigned UHOLD   = 1;

  typedef struct packed {
    logic [3:0]  ack;
    logic [23:0] data;
    logic [3:0]  xrun;
    logic [1:0]  primed;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  flush_i = '0;
  logic [1:0]  wr_i = '0;
  logic [1:0]  lrck_i = '0;
  logic [47:0] wdata_i = '0;
  logic [3:0]  pop_i = '0;
  logic        xrun_clr_i = 1'b0;
  logic [3:0]  ack_o;
  logic [23:0] data_o;
  logic [1:0]  primed_o;
  logic [3:0]  xrun_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;

  sb_t         sb_q [$];
  sb_t         mon_e;
  logic [23:0] mq [NST][$];
  logic [3:0]  m_pr;
  logic [23:0] m_held [NST];
  logic [3:0]  m_xrun;

  dai_rxbuf_bank #(
    .NUM_CH(NCH), .DEPTH_LOG2(DLOG2), .PREFILL(PREFILL), .UNDER_HOLD(UHOLD)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .wr_i(wr_i), .lrck_i(lrck_i),
    .wdata_i(wdata_i), .pop_i(pop_i), .ack_o(ack_o), .data_o(data_o),
    .primed_o(primed_o), .xrun_o(xrun_o), .xrun_clr_i(xrun_clr_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int s = 0; s < int'(NST); s++) begin
      mq[s].delete();
      m_held[s] = '0;
    end
    m_pr   = '0;
    m_xrun = '0;
    sb_q.delete();
  endtask

  // Reference model: advance one clock and push the expected post-edge outputs
  task automatic model_step(input logic [1:0] fl, input logic [1:0] wr, input logic [1:0] lr,
                            input logic [47:0] wd, input logic [3:0] pop, input logic clr);
    sb_t        e;
    int         sel;
    int         st;
    logic [3:0] ev;
    e        = '0;
    ev       = '0;
    sel      = -1;
    e.primed = {m_pr[3] & m_pr[2], m_pr[1] & m_pr[0]};
    for (int s = 0; s < int'(NST); s++) if (pop[s] && sel < 0) sel = s;
    if (sel >= 0) begin
      e.ack[sel] = 1'b1;
      if (fl[sel/2] || !m_pr[sel]) begin
        e.data = '0;
      end else if (mq[sel].size() > 0) begin
        e.data      = mq[sel].pop_front();
        m_held[sel] = e.data;
      end else begin
        e.data  = (UHOLD != 0) ? m_held[sel] : '0;
        ev[sel] = 1'b1;
      end
    end
    for (int c = 0; c < int'(NCH); c++) begin
      if (fl[c]) begin
        for (int k = 2*c; k <= 2*c+1; k++) begin
          mq[k].delete();
          m_pr[k]   = 1'b0;
          m_held[k] = '0;
        end
      end else if (wr[c]) begin
        st = lr[c] ? 2*c : 2*c+1;
        if (mq[st].size() == int'(DEPTH)) begin
          void'(mq[st].pop_front());
          ev[st] = 1'b1;
        end
        mq[st].push_back(wd[24*c +: 24]);
      end
    end
    for (int s = 0; s < int'(NST); s++) if (mq[s].size() >= int'(PREFILL)) m_pr[s] = 1'b1;
    m_xrun = (clr ? 4'h0 : m_xrun) | ev;
    e.xrun = m_xrun;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, predict it, then release the pulse inputs
  task automatic drive(input logic [1:0] fl, input logic [1:0] wr, input logic [1:0] lr,
                       input logic [47:0] wd, input logic [3:0] pop, input logic clr);
    flush_i = fl; wr_i = wr; lrck_i = lr; wdata_i = wd; pop_i = pop; xrun_clr_i = clr;
    model_step(fl, wr, lr, wd, pop, clr);
    @(posedge clk);
    #2;
    flush_i = '0; wr_i = '0; lrck_i = '0; wdata_i = '0; pop_i = '0; xrun_clr_i = 1'b0;
  endtask

  task automatic wr_l0(input logic [23:0] d);
    drive(2'b00, 2'b01, 2'b01, {24'h0, d}, 4'h0, 1'b0);
  endtask

  task automatic wr_r0(input logic [23:0] d);
    drive(2'b00, 2'b01, 2'b00, {24'h0, d}, 4'h0, 1'b0);
  endtask

  task automatic pop_s(input logic [3:0] p);
    drive(2'b00, 2'b00, 2'b00, 48'h0, p, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 2'b00, 2'b00, 48'h0, 4'h0, 1'b0);
  endtask

  // Scoreboard: compare each post-edge output set against the oldest prediction
  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: DUT cycle with no prediction at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        if (ack_o !== mon_e.ack) begin
          n_fail++;
          $display("FAIL ack_o at %0t: got %b expected %b", $time, ack_o, mon_e.ack);
        end
        n_chk++;
        if (data_o !== mon_e.data) begin
          n_fail++;
          $display("FAIL data_o at %0t: got %h expected %h", $time, data_o, mon_e.data);
        end
        n_chk++;
        if (xrun_o !== mon_e.xrun) begin
          n_fail++;
          $display("FAIL xrun_o at %0t: got %b expected %b", $time, xrun_o, mon_e.xrun);
        end
        n_chk++;
        if (primed_o !== mon_e.primed) begin
          n_fail++;
          $display("FAIL primed_o at %0t: got %b expected %b", $time, primed_o, mon_e.primed);
        end
      end
    end
  end

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if ({ack_o, data_o, primed_o, xrun_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b data=%h primed=%b xrun=%b expected all zero",
               ack_o, data_o, primed_o, xrun_o);
    end
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_prefill();
    wr_l0(24'd1); wr_l0(24'd2); wr_l0(24'd3);
    pop_s(4'b0001);
    n_chk++;
    if (ack_o !== 4'b0001 || data_o !== 24'h0) begin
      n_fail++;
      $display("FAIL unprimed_pop: got ack=%b data=%h expected 0001/000000", ack_o, data_o);
    end
    wr_l0(24'd4);
    for (int i = 0; i < 4; i++) wr_r0(24'h100 + 24'(i));
    idle(2);
    n_chk++;
    if (primed_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL primed_after_prefill: got %b expected 1", primed_o[0]);
    end
    for (int i = 0; i < 4; i++) pop_s(4'b0001);
  endtask

  task automatic test_underrun_clear();
    drive(2'b01, 2'b00, 2'b00, 48'h0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wr_l0(24'h11 + 24'(i));
      wr_r0(24'h21 + 24'(i));
    end
    pop_s(4'b0001); pop_s(4'b0001); pop_s(4'b0001); pop_s(4'b0001);
    pop_s(4'b0001);
    n_chk++;
    if (data_o !== 24'h14 || xrun_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_hold: got data=%h xrun=%b expected 000014 / xrun[0]=1",
               data_o, xrun_o);
    end
    drive(2'b00, 2'b00, 2'b00, 48'h0, 4'h0, 1'b1);
    drive(2'b00, 2'b00, 2'b00, 48'h0, 4'b0001, 1'b1);
    drive(2'b00, 2'b00, 2'b00, 48'h0, 4'h0, 1'b1);
  endtask

  task automatic test_overrun();
    drive(2'b01, 2'b00, 2'b00, 48'h0, 4'h0, 1'b0);
    for (int i = 1; i <= 17; i++) wr_l0(24'(i));
    n_chk++;
    if (xrun_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_flag: got %b expected 1", xrun_o[0]);
    end
    drive(2'b00, 2'b00, 2'b00, 48'h0, 4'h0, 1'b1);
    drive(2'b00, 2'b01, 2'b01, {24'h0, 24'h99}, 4'b0001, 1'b0);
    for (int i = 0; i < 16; i++) pop_s(4'b0001);
    drive(2'b00, 2'b01, 2'b01, {24'h0, 24'hAA}, 4'b0001, 1'b0);
    pop_s(4'b0001);
    drive(2'b00, 2'b00, 2'b00, 48'h0, 4'h0, 1'b1);
  endtask

  task automatic test_arb_flush();
    for (int i = 0; i < 5; i++) begin
      wr_l0(24'h300 + 24'(i));
      wr_r0(24'h400 + 24'(i));
    end
    pop_s(4'b0110);
    n_chk++;
    if (ack_o !== 4'b0010) begin
      n_fail++;
      $display("FAIL pop_arbitration: got ack=%b expected 0010", ack_o);
    end
    pop_s(4'b1100);
    drive(2'b01, 2'b01, 2'b01, {24'h0, 24'h555}, 4'b0001, 1'b0);
    n_chk++;
    if (ack_o !== 4'b0001 || data_o !== 24'h0) begin
      n_fail++;
      $display("FAIL flush_pop: got ack=%b data=%h expected 0001/000000", ack_o, data_o);
    end
    idle(2);
    n_chk++;
    if (primed_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL primed_after_flush: got %b expected 0", primed_o[0]);
    end
    pop_s(4'b0001);
  endtask

  task automatic test_random();
    logic [1:0]  fl, wr, lr;
    logic [47:0] wd;
    logic [3:0]  p;
    for (int i = 0; i < 400; i++) begin
      fl = ($urandom_range(0, 60) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      wr = 2'($urandom);
      lr = 2'($urandom);
      wd = {24'($urandom), 24'($urandom)};
      p  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      drive(fl, wr, lr, wd, p, ($urandom_range(0, 25) == 0));
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      wr_l0(24'h700 + 24'(i));
      wr_r0(24'h800 + 24'(i));
    end
    idle(2);
    pop_s(4'b0001);
    mon_en = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    n_chk++;
    if (ack_o !== 4'h0 || data_o !== 24'h0 || primed_o !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset: got ack=%b data=%h primed=%b expected zeros",
               ack_o, data_o, primed_o);
    end
    model_reset();
    @(posedge clk);
    #2;
    rst    = 1'b0;
    mon_en = 1'b1;
    pop_s(4'b0001);
    idle(1);
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_underrun_clear();
    test_overrun();
    test_arb_flush();
    test_random();
    test_async_reset();
    mon_en = 1'b0;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending predictions expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
